// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU sprite-update scheduler.
// Entries pair a 3-bit sprite id with the 32-bit payload written by the CPU.
package ppu_pkg;

  localparam int NUM_SPRITES = 8;
  localparam int VBLANK_LINE = 480;
  localparam int ID_W        = 3;
  localparam int DATA_W      = 32;
  localparam int ENTRY_W     = ID_W + DATA_W;

  localparam logic [3:0] CTRL_ADDR = 4'd15;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 2'd0;
  localparam sched_state_t ST_DRAIN = 2'd1;
  localparam sched_state_t ST_DONE  = 2'd2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } sched_entry_t;

  // Addresses 0..7 target a sprite; 8..15 never enter the buffer.
  function automatic logic is_sprite_addr(input logic [3:0] addr);
    return (addr[3] == 1'b0);
  endfunction

endpackage

// File: rtl/ppu_sched_fifo.sv
// Circular buffer of pending sprite writes with registered read data.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module ppu_sched_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW:0]        count_reg;
  logic [ENTRY_W-1:0] rd_data_reg;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = rd_data_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ppu_update_scheduler.sv
// Buffers CPU sprite writes during active video and commits them during vblank.
// Optional drop counter enabled by defining PPU_SCHED_DROPCNT_EN.
module ppu_update_scheduler #(
  parameter int FIFO_DEPTH  = 16,
  parameter int NUM_SPRITES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chipselect,
  input  logic                   write,
  input  logic [3:0]             address,
  input  logic [31:0]            writedata,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  output logic [NUM_SPRITES-1:0] sprite_wr,
  output logic [31:0]            sprite_wdata,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic                   frame_done,
  output logic [7:0]             drop_count
);

  import ppu_pkg::*;

  sched_state_t       state_reg;
  sched_state_t       state_next;
  logic               pop;
  logic               wr_valid;
  logic               sprite_sel;
  logic               ctrl_sel;
  logic               drop;
  logic               fifo_empty;
  logic               vblank_start;
  logic               in_vblank;
  logic               commit_valid_reg;
  logic [ENTRY_W-1:0] push_data;
  sched_entry_t       head;
  logic               overflow_reg;

  assign wr_valid     = chipselect && write;
  assign sprite_sel   = wr_valid && is_sprite_addr(address);
  assign ctrl_sel     = wr_valid && (address == CTRL_ADDR);
  assign drop         = sprite_sel && fifo_full && !pop;
  assign push_data    = {address[2:0], writedata};
  assign vblank_start = (vcount == 10'(VBLANK_LINE)) && (hcount == '0);
  assign in_vblank    = (vcount >= 10'(VBLANK_LINE));

  logic [ENTRY_W-1:0] fifo_rd_data;

  ppu_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (sprite_sel),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head = sched_entry_t'(fifo_rd_data);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (vblank_start) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Line 0 ends the window; whatever is left waits for the next vblank.
        if (vcount == '0 || fifo_empty) begin
          state_next = ST_DONE;
        end else if (in_vblank) begin
          pop = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      commit_valid_reg <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      commit_valid_reg <= pop;
      if (ctrl_sel && writedata[0]) begin
        overflow_reg <= 1'b0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // The FIFO read register only updates on a pop, so the payload holds between commits.
  assign sprite_wdata = head.data;
  assign overflow     = overflow_reg;
  assign frame_done   = (state_reg == ST_DONE);

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_strobe
    assign sprite_wr[gi] = commit_valid_reg && (32'(head.id) == gi);
  end

`ifdef PPU_SCHED_DROPCNT_EN
  logic [7:0] drop_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count_reg <= '0;
    end else if (ctrl_sel && writedata[1]) begin
      drop_count_reg <= '0;
    end else if (drop && drop_count_reg != 8'hFF) begin
      drop_count_reg <= drop_count_reg + 1'b1;
    end
  end

  assign drop_count = drop_count_reg;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_ppu_update_scheduler.sv
// Randomized and directed checks of ppu_update_scheduler against a queue model:
// the pending-write queue is the buffer contents, commits pop it in order.
module tb_ppu_update_scheduler;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [9:0]  hcount = 10'd10;
  logic [9:0]  vcount = 10'd100;
  logic [7:0]  sprite_wr;
  logic [31:0] sprite_wdata;
  logic        fifo_full;
  logic        overflow;
  logic        frame_done;
  logic [7:0]  drop_count;

  ppu_update_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .NUM_SPRITES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .hcount       (hcount),
    .vcount       (vcount),
    .sprite_wr    (sprite_wr),
    .sprite_wdata (sprite_wdata),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .frame_done   (frame_done),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
  } entry_t;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     commit_cnt = 0;
  int     frame_cnt = 0;
  int     frames_exp = 0;
  int     last_commit_cyc = -1;
  int     frame_cyc = -1;
  int     trig_cyc = 0;
  logic   prev_fd = 1'b0;
  logic   ovf_m = 1'b0;
  int     drops_m = 0;
  logic [7:0] exp_wr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest pending write.
  always @(negedge clk) begin
    if (sprite_wr != '0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_commit: got sprite_wr=%02h data=%08h, required no commit", sprite_wr, sprite_wdata);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        exp_wr = 8'b1 << e.id;
        if (sprite_wr !== exp_wr || sprite_wdata !== e.data) begin
          n_fail++;
          $display("FAIL commit: got sprite_wr=%02h data=%08h, required sprite_wr=%02h data=%08h",
                   sprite_wr, sprite_wdata, exp_wr, e.data);
        end else begin
          $display("commit cyc=%0d sprite_wr=%02h data=%08h", cyc, sprite_wr, sprite_wdata);
        end
      end
      n_checks++;
      if (vcount > 0 && vcount < 480) begin
        n_fail++;
        $display("FAIL commit_in_active: got commit at vcount=%0d, required vcount>=480", vcount);
      end
      commit_cnt++;
      last_commit_cyc = cyc;
    end
    if (frame_done) begin
      n_checks++;
      if (prev_fd) begin
        n_fail++;
        $display("FAIL frame_done_width: got 2+ cycle pulse, required 1 cycle");
      end
      frame_cnt++;
      frame_cyc = cyc;
    end
    prev_fd = frame_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_dc();
`ifdef PPU_SCHED_DROPCNT_EN
    return drops_m;
`else
    return 0;
`endif
  endfunction

  // popping=1 means the scheduler is known to pop in the same cycle.
  task automatic do_write(input logic cs, input logic [3:0] addr, input logic [31:0] data, input logic popping);
    entry_t e;
    if (cs && !addr[3]) begin
      if (popping || exp_q.size() < DEPTH) begin
        e.id   = addr[2:0];
        e.data = data;
        exp_q.push_back(e);
      end else begin
        ovf_m = 1'b1;
        if (drops_m < 255) drops_m++;
      end
    end else if (cs && addr == 4'd15) begin
      if (data[0]) ovf_m = 1'b0;
      if (data[1]) drops_m = 0;
    end
    chipselect = cs;
    write      = 1'b1;
    address    = addr;
    writedata  = data;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    $display("write cs=%0b addr=%0d data=%08h pending=%0d", cs, addr, data, exp_q.size());
    check("fifo_full", 32'(fifo_full), popping ? 32'd1 : 32'(exp_q.size() >= DEPTH));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("drop_count", 32'(drop_count), 32'(exp_dc()));
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      do_write(1'b1, 4'($urandom_range(0, 7)), $urandom, 1'b0);
    end
  endtask

  task automatic vblank(input int len);
    vcount   = 10'd480;
    hcount   = 10'd0;
    trig_cyc = cyc;
    tick();
    hcount = 10'd1;
    for (int i = 0; i < len; i++) begin
      tick();
      hcount = hcount + 1'b1;
    end
    vcount = 10'd0;
    hcount = 10'd3;
    repeat (3) tick();
    vcount = 10'd100;
    hcount = 10'd10;
    frames_exp++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int k;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_sprite_wr", 32'(sprite_wr), 32'd0);
    check("rst_sprite_wdata", sprite_wdata, 32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);

    // Single write waits for vblank, then commits two cycles after the trigger edge.
    do_write(1'b1, 4'd2, 32'h00640050, 1'b0);
    base = commit_cnt;
    repeat (10) tick();
    check("no_commit_active", 32'(commit_cnt), 32'(base));
    vblank(10);
    check("single_commit_cnt", 32'(commit_cnt), 32'(base + 1));
    check("commit_latency", 32'(last_commit_cyc), 32'(trig_cyc + 2));
    check("frame_done_cycle", 32'(frame_cyc), 32'(trig_cyc + 3));

    // Ignored addresses and idle control writes.
    base = commit_cnt;
    do_write(1'b1, 4'd9, 32'hDEADBEEF, 1'b0);
    do_write(1'b1, 4'd12, 32'h12345678, 1'b0);
    do_write(1'b1, 4'd15, 32'h0, 1'b0);
    vblank(8);
    check("ignored_addr_no_commit", 32'(commit_cnt), 32'(base));

    // Overfill: 17th write is dropped, 16 commit in order.
    base = commit_cnt;
    fill(17);
    vblank(25);
    check("overfill_commits", 32'(commit_cnt), 32'(base + 16));

    // Clear overflow; saturate and clear the drop counter.
    do_write(1'b1, 4'd15, 32'h1, 1'b0);
    fill(16);
    for (int i = 0; i < 260; i++) begin
      do_write(1'b1, 4'($urandom_range(0, 7)), $urandom, 1'b0);
    end
    do_write(1'b1, 4'd15, 32'h2, 1'b0);
    do_write(1'b1, 4'd15, 32'h1, 1'b0);
    vblank(25);

    // Full buffer entering drain with a write every cycle: nothing dropped.
    base = commit_cnt;
    fill(16);
    vcount   = 10'd480;
    hcount   = 10'd0;
    tick();
    hcount = 10'd1;
    for (int i = 0; i < 6; i++) begin
      do_write(1'b1, 4'($urandom_range(0, 7)), $urandom, 1'b1);
    end
    for (int i = 0; i < 30; i++) tick();
    vcount = 10'd0;
    hcount = 10'd3;
    repeat (3) tick();
    vcount = 10'd100;
    hcount = 10'd10;
    frames_exp++;
    check("full_drain_commits", 32'(commit_cnt), 32'(base + 22));

    // Drain cut short by line 0; remainder goes out next vblank.
    fill(12);
    vblank(4);
    check("cut_leaves_entries", 32'(exp_q.size() > 0), 32'd1);
    vblank(25);
    check("cut_remainder_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a drain.
    fill(10);
    vcount = 10'd480;
    hcount = 10'd0;
    tick();
    hcount = 10'd1;
    base = commit_cnt;
    k = 0;
    while (commit_cnt < base + 3 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("reach_3_commits", 32'(commit_cnt), 32'(base + 3));
    reset = 1'b0;
    #1;
    check("midrst_sprite_wr", 32'(sprite_wr), 32'd0);
    check("midrst_sprite_wdata", sprite_wdata, 32'd0);
    check("midrst_fifo_full", 32'(fifo_full), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_drop_count", 32'(drop_count), 32'd0);
    exp_q.delete();
    ovf_m   = 1'b0;
    drops_m = 0;
    repeat (2) tick();
    reset  = 1'b1;
    vcount = 10'd100;
    hcount = 10'd7;
    repeat (20) tick();
    vblank(10);
    check("post_reset_no_commits", 32'(commit_cnt), 32'(base + 3));

    // Random frames.
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(0, 22);
      for (int i = 0; i < n; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      do_write(1'b1, 4'($urandom_range(0, 7)), $urandom, 1'b0);
        else if (r == 7) do_write(1'b1, 4'($urandom_range(8, 14)), $urandom, 1'b0);
        else if (r == 8) do_write(1'b1, 4'd15, $urandom, 1'b0);
        else             do_write(1'b0, 4'($urandom_range(0, 7)), $urandom, 1'b0);
      end
      vblank(25);
      check("random_frame_drained", 32'(exp_q.size()), 32'd0);
    end

    repeat (5) tick();
    check("frame_done_count", 32'(frame_cnt), 32'(frames_exp));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
